// File: rtl/video_src_sched.sv
// Frame-synchronous pixel source selector with per-line frame-buffer fetch sequencing.
// Source changes land on vsync leading edges; frame-buffer lines not fetched in time are blanked.
module video_src_sched #(
    parameter logic        VS_POL         = 1'b1,
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned FB_SRC         = 1,
    parameter int unsigned V_ACTIVE       = 720,
    parameter int unsigned FRAMES_PER_SRC = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [23:0] src0_rgb,
    input  logic [23:0] src1_rgb,
    input  logic [23:0] src2_rgb,
    input  logic [23:0] src3_rgb,
    input  logic        sel_wr,
    input  logic [1:0]  sel_data,
    input  logic        auto_en,
    input  logic        line_ack,
    output logic        line_req,
    output logic [11:0] line_num,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [23:0] out_rgb,
    output logic [1:0]  cur_src,
    output logic [15:0] frame_cnt,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam int unsigned RGB_W  = 24;
    localparam int unsigned SRC_W  = 2;
    localparam int unsigned LINE_W = 12;
    localparam int unsigned FCNT_W = 16;
    localparam int unsigned FRM_W  = 16;

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_READY} fstate_e;

    fstate_e             state_q, state_d;
    logic [LINE_W-1:0]   line_num_q, line_num_d;
    logic                line_req_q, line_req_d;
    logic                vs_act_q, de_prev_q;
    logic [SRC_W-1:0]    pending_src_q, pending_src_d;
    logic                pending_valid_q, pending_valid_d;
    logic [SRC_W-1:0]    cur_src_q, cur_src_d;
    logic [FRM_W-1:0]    frm_in_src_q, frm_in_src_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                line_bad_q, line_bad_d;
    logic                underrun_q, underrun_d;
    logic                out_hs_q, out_vs_q, out_de_q;
    logic [RGB_W-1:0]    out_rgb_q, out_rgb_d;

    logic vs_act, frame_start, de_rise, de_fall, sel_ok, bad_set;

    assign vs_act      = (in_vs == VS_POL);
    assign frame_start = vs_act && !vs_act_q;
    assign de_rise     = in_de && !de_prev_q;
    assign de_fall     = !in_de && de_prev_q;
    assign sel_ok      = sel_wr && (32'(sel_data) < NUM_SRC);

    // State register and all pipeline/status flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= F_IDLE;
            line_num_q      <= '0;
            line_req_q      <= 1'b0;
            vs_act_q        <= 1'b0;
            de_prev_q       <= 1'b0;
            pending_src_q   <= '0;
            pending_valid_q <= 1'b0;
            cur_src_q       <= '0;
            frm_in_src_q    <= '0;
            frame_cnt_q     <= '0;
            line_bad_q      <= 1'b0;
            underrun_q      <= 1'b0;
            out_hs_q        <= 1'b0;
            out_vs_q        <= 1'b0;
            out_de_q        <= 1'b0;
            out_rgb_q       <= '0;
        end else begin
            state_q         <= state_d;
            line_num_q      <= line_num_d;
            line_req_q      <= line_req_d;
            vs_act_q        <= vs_act;
            de_prev_q       <= in_de;
            pending_src_q   <= pending_src_d;
            pending_valid_q <= pending_valid_d;
            cur_src_q       <= cur_src_d;
            frm_in_src_q    <= frm_in_src_d;
            frame_cnt_q     <= frame_cnt_d;
            line_bad_q      <= line_bad_d;
            underrun_q      <= underrun_d;
            out_hs_q        <= in_hs;
            out_vs_q        <= in_vs;
            out_de_q        <= in_de;
            out_rgb_q       <= out_rgb_d;
        end
    end

    // Source selection and fetch next-state
    always_comb begin
        pending_src_d   = pending_src_q;
        pending_valid_d = pending_valid_q;
        cur_src_d       = cur_src_q;
        frm_in_src_d    = frm_in_src_q;
        frame_cnt_d     = frame_cnt_q;
        state_d         = state_q;
        line_num_d      = line_num_q;

        if (frame_start) begin
            frame_cnt_d     = frame_cnt_q + FCNT_W'(1);
            pending_valid_d = 1'b0;
            frm_in_src_d    = '0;
            if (sel_ok) begin
                cur_src_d = sel_data;
            end else if (pending_valid_q) begin
                cur_src_d = pending_src_q;
            end else if (auto_en && frm_in_src_q == FRM_W'(FRAMES_PER_SRC - 1)) begin
                cur_src_d = (cur_src_q == SRC_W'(NUM_SRC - 1)) ? '0 : cur_src_q + SRC_W'(1);
            end else begin
                frm_in_src_d = (frm_in_src_q == FRM_W'(FRAMES_PER_SRC - 1)) ?
                               frm_in_src_q : frm_in_src_q + FRM_W'(1);
            end
        end else if (sel_ok) begin
            pending_src_d   = sel_data;
            pending_valid_d = 1'b1;
        end

        if (frame_start) begin
            line_num_d = '0;
            state_d    = (cur_src_d == SRC_W'(FB_SRC)) ? F_REQ : F_IDLE;
        end else if (de_fall && (state_q == F_REQ || state_q == F_READY)) begin
            // An unacknowledged request is simply re-aimed at the next line
            if (line_num_q == LINE_W'(V_ACTIVE - 1)) begin
                state_d = F_IDLE;
            end else begin
                line_num_d = line_num_q + LINE_W'(1);
                state_d    = F_REQ;
            end
        end else if (state_q == F_REQ && line_ack) begin
            state_d = F_READY;
        end
    end

    // Registered outputs: request level, blanking, underrun, pixel mux
    always_comb begin
        line_req_d = (state_d == F_REQ);
        bad_set    = de_rise && (cur_src_q == SRC_W'(FB_SRC)) && (state_q != F_READY);
        line_bad_d = line_bad_q;
        underrun_d = underrun_q;
        out_rgb_d  = '0;

        if (bad_set) begin
            line_bad_d = 1'b1;
        end else if (de_fall) begin
            line_bad_d = 1'b0;
        end

        if (bad_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        if (in_de && !line_bad_q && !bad_set) begin
            case (cur_src_q)
                2'd0:    out_rgb_d = src0_rgb;
                2'd1:    out_rgb_d = src1_rgb;
                2'd2:    out_rgb_d = src2_rgb;
                default: out_rgb_d = src3_rgb;
            endcase
        end
    end

    assign line_req  = line_req_q;
    assign line_num  = line_num_q;
    assign out_hs    = out_hs_q;
    assign out_vs    = out_vs_q;
    assign out_de    = out_de_q;
    assign out_rgb   = out_rgb_q;
    assign cur_src   = cur_src_q;
    assign frame_cnt = frame_cnt_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_video_src_sched.sv
// Directed bench for video_src_sched: small raster, per-pixel output model and a
// frame-buffer reader that acks each request five cycles later.
module tb_video_src_sched;
    localparam int V_ACT  = 10;
    localparam int H_ACT  = 4;
    localparam int H_BLK  = 8;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 8;

    logic        clk;
    logic        rst;
    logic        in_hs, in_vs, in_de;
    logic [23:0] src0_rgb, src1_rgb, src2_rgb, src3_rgb;
    logic        sel_wr;
    logic [1:0]  sel_data;
    logic        auto_en;
    logic        line_ack;
    logic        line_req;
    logic [11:0] line_num;
    logic        out_hs, out_vs, out_de;
    logic [23:0] out_rgb;
    logic [1:0]  cur_src;
    logic [15:0] frame_cnt;
    logic        underrun;
    logic        underrun_clr;

    video_src_sched #(
        .VS_POL(1'b1), .NUM_SRC(4), .FB_SRC(1), .V_ACTIVE(V_ACT), .FRAMES_PER_SRC(2)
    ) dut (
        .clk(clk), .rst(rst), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
        .src0_rgb(src0_rgb), .src1_rgb(src1_rgb), .src2_rgb(src2_rgb), .src3_rgb(src3_rgb),
        .sel_wr(sel_wr), .sel_data(sel_data), .auto_en(auto_en), .line_ack(line_ack),
        .line_req(line_req), .line_num(line_num), .out_hs(out_hs), .out_vs(out_vs),
        .out_de(out_de), .out_rgb(out_rgb), .cur_src(cur_src), .frame_cnt(frame_cnt),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        rst_req = 1'b1;
    logic        sel_req = 1'b0;
    logic [1:0]  sel_val = 2'd0;
    logic        clr_req = 1'b0;
    int          exp_src = 0;
    int          cur_line = -1;
    int          bad_line = -1;
    int          hold_line = -1;
    logic [15:0] pix = 16'd0;
    logic        have_exp = 1'b0;
    logic [23:0] exp_rgb = 24'd0;
    logic        exp_hs = 1'b0, exp_vs = 1'b0, exp_de = 1'b0;
    logic        req_seen = 1'b0;
    int          acks = 0;
    int          ack_sum = 0;
    int          ack_last = -1;
    int          ack_cnt = 0;
    int          prev_num = 0;
    int          auto_seq [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] src_val(input int s, input logic [15:0] p);
        case (s)
            0:       return {8'h10, p};
            1:       return {8'h21, p};
            2:       return {8'h42, p};
            default: return {8'h83, p};
        endcase
    endfunction

    // One pixel clock: check last cycle's outputs, then drive this cycle's inputs
    task automatic tick(input logic hs, input logic vs, input logic de);
        @(negedge clk);
        if (have_exp) begin
            chk("out_rgb", 32'(out_rgb), 32'(exp_rgb));
            chk("out_hs", 32'(out_hs), 32'(exp_hs));
            chk("out_vs", 32'(out_vs), 32'(exp_vs));
            chk("out_de", 32'(out_de), 32'(exp_de));
        end
        if (line_req === 1'b1) req_seen = 1'b1;
        rst          = rst_req;
        sel_wr       = sel_req;
        sel_data     = sel_val;
        sel_req      = 1'b0;
        underrun_clr = clr_req;
        clr_req      = 1'b0;
        in_hs        = hs;
        in_vs        = vs;
        in_de        = de;
        pix          = pix + 16'd1;
        src0_rgb     = src_val(0, pix);
        src1_rgb     = src_val(1, pix);
        src2_rgb     = src_val(2, pix);
        src3_rgb     = src_val(3, pix);
        have_exp     = 1'b1;
        if (rst_req) begin
            exp_hs = 1'b0; exp_vs = 1'b0; exp_de = 1'b0; exp_rgb = 24'd0;
        end else begin
            exp_hs  = hs;
            exp_vs  = vs;
            exp_de  = de;
            exp_rgb = (de && cur_line != bad_line) ? src_val(exp_src, pix) : 24'd0;
        end
    endtask

    task automatic frame_head();
        cur_line = -1;
        repeat (V_SYNC) tick(1'b0, 1'b1, 1'b0);
        repeat (V_BP) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic lines(input int first, input int last);
        for (int l = first; l <= last; l++) begin
            cur_line = l;
            repeat (H_ACT) tick(1'b0, 1'b0, 1'b1);
            cur_line = -1;
            repeat (2) tick(1'b1, 1'b0, 1'b0);
            repeat (H_BLK - 2) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        rst_req = 1'b0;
        exp_src = 0;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    // Frame-buffer reader: ack five cycles into each request unless held back
    initial begin
        line_ack = 1'b0;
        forever begin
            @(negedge clk);
            line_ack = 1'b0;
            if (line_req !== 1'b1) begin
                ack_cnt = 0;
            end else if (int'(line_num) != prev_num) begin
                ack_cnt = 1;
            end else begin
                ack_cnt++;
            end
            prev_num = int'(line_num);
            if (line_req === 1'b1 && ack_cnt == 5 && int'(line_num) != hold_line) begin
                line_ack = 1'b1;
                acks++;
                ack_sum += int'(line_num);
                ack_last = int'(line_num);
            end
        end
    end

    initial begin
        rst = 1'b1; in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
        src0_rgb = '0; src1_rgb = '0; src2_rgb = '0; src3_rgb = '0;
        sel_wr = 1'b0; sel_data = 2'd0; auto_en = 1'b0; underrun_clr = 1'b0;

        // Reset values
        do_reset();
        chk("rst_cur_src", 32'(cur_src), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_line_req", 32'(line_req), 32'd0);
        chk("rst_line_num", 32'(line_num), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // Three frames on source 0, no fetches
        req_seen = 1'b0;
        repeat (3) begin frame_head(); lines(0, V_ACT - 1); end
        chk("t1_cur_src", 32'(cur_src), 32'd0);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("t1_req_seen", 32'(req_seen), 32'd0);

        // Manual select: takes effect only at the next vsync edge
        frame_head();
        lines(0, 4);
        sel_req = 1'b1; sel_val = 2'd2;
        lines(5, V_ACT - 1);
        chk("t2_hold_src", 32'(cur_src), 32'd0);
        frame_head();
        chk("t2_apply_src", 32'(cur_src), 32'd2);
        exp_src = 2;
        lines(0, 4);
        sel_req = 1'b1; sel_val = 2'd0;
        lines(5, V_ACT - 1);
        chk("t2_pend_hold", 32'(cur_src), 32'd2);
        sel_req = 1'b1; sel_val = 2'd3;
        frame_head();
        chk("t2_same_cycle_wins", 32'(cur_src), 32'd3);
        exp_src = 3;
        lines(0, V_ACT - 1);
        frame_head();
        chk("t2_pend_cleared", 32'(cur_src), 32'd3);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd7);
        lines(0, V_ACT - 1);

        // Auto-cycling, two frames per source
        do_reset();
        auto_en = 1'b1;
        for (int f = 0; f < 9; f++) begin
            frame_head();
            chk($sformatf("t3_auto_f%0d", f), 32'(cur_src), 32'(auto_seq[f]));
            exp_src = auto_seq[f];
            lines(0, V_ACT - 1);
        end
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd9);
        chk("t3_underrun", 32'(underrun), 32'd0);
        auto_en = 1'b0;

        // Frame-buffer source with timely acks
        do_reset();
        sel_req = 1'b1; sel_val = 2'd1;
        tick(1'b0, 1'b0, 1'b0);
        acks = 0; ack_sum = 0; ack_last = -1;
        frame_head();
        chk("t4_cur_src", 32'(cur_src), 32'd1);
        exp_src = 1;
        lines(0, V_ACT - 1);
        chk("t4_acks", 32'(acks), 32'(V_ACT));
        chk("t4_ack_sum", 32'(ack_sum), 32'(V_ACT * (V_ACT - 1) / 2));
        chk("t4_ack_last", 32'(ack_last), 32'(V_ACT - 1));
        chk("t4_underrun", 32'(underrun), 32'd0);
        chk("t4_idle_req", 32'(line_req), 32'd0);

        // Ack withheld for line 7: blanked line, underrun, line 8 requested at de_fall
        acks = 0; ack_sum = 0;
        hold_line = 7; bad_line = 7;
        frame_head();
        lines(0, 6);
        chk("t5_pre_underrun", 32'(underrun), 32'd0);
        cur_line = 7;
        repeat (H_ACT) tick(1'b0, 1'b0, 1'b1);
        cur_line = -1;
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        chk("t5_underrun_set", 32'(underrun), 32'd1);
        chk("t5_next_req", 32'(line_req), 32'd1);
        chk("t5_next_num", 32'(line_num), 32'd8);
        repeat (H_BLK - 2) tick(1'b0, 1'b0, 1'b0);
        lines(8, V_ACT - 1);
        hold_line = -1; bad_line = -1;
        chk("t5_acks", 32'(acks), 32'(V_ACT - 1));
        chk("t5_ack_sum", 32'(ack_sum), 32'(V_ACT * (V_ACT - 1) / 2 - 7));
        chk("t5_underrun_sticky", 32'(underrun), 32'd1);
        clr_req = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        chk("t5_underrun_clr", 32'(underrun), 32'd0);

        // Reset while a request is outstanding
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk("t6_req_before", 32'(line_req), 32'd1);
        rst_req = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst_req = 1'b0;
        exp_src = 0;
        tick(1'b0, 1'b0, 1'b0);
        chk("t6_line_req", 32'(line_req), 32'd0);
        chk("t6_cur_src", 32'(cur_src), 32'd0);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_out_rgb", 32'(out_rgb), 32'd0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        frame_head();
        lines(0, V_ACT - 1);
        chk("t6_resume_src", 32'(cur_src), 32'd0);
        chk("t6_resume_cnt", 32'(frame_cnt), 32'd1);
        tick(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
